// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-side bundle for inst_prefetch_buffer: redirect/stall from ID, memory handshake, IF/ID outputs.
interface inst_prefetch_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     stall;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic                     mem_ack;
    logic [31:0]              mem_rdata;
    logic                     inst_valid;
    logic [31:0]              inst_out;
    logic [31:0]              pc_out;
    logic [31:0]              npc_out;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        input  redirect_valid, redirect_pc, stall, mem_ack, mem_rdata,
        output mem_req, mem_addr, inst_valid, inst_out, pc_out, npc_out, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, stall, mem_ack, mem_rdata,
        input  mem_req, mem_addr, inst_valid, inst_out, pc_out, npc_out, occupancy
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: one outstanding memory request, DEPTH-entry {pc, inst} FIFO, redirect flush.
// Optional PREFETCH_BYPASS_EN forwards an ack straight to the outputs when the FIFO is empty.
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_prefetch_buffer_if.master  bus
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   OW      = PW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d, occ_after_pop;
    logic          valid_q;
    logic [31:0]   head_inst_q, head_inst_d;
    logic [31:0]   head_pc_q, head_pc_d;

    logic          redirect;
    logic [31:0]   redirect_target;
    logic          ack_ok, accept, bypass_hit, bypass_take, push, pop;

    logic          out_valid;
    logic [31:0]   out_inst, out_pc;

    always_comb begin
        redirect        = bus.redirect_valid;
        redirect_target = {bus.redirect_pc[31:2], 2'b00};
        ack_ok          = mem_req_q && bus.mem_ack;
        accept          = (state_q == WAIT) && ack_ok && !redirect;
        bypass_hit      = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        bypass_hit      = accept && (occ_q == '0);
`endif
        bypass_take     = bypass_hit && !bus.stall;
        push            = accept && !bypass_take;
        pop             = valid_q && !bus.stall && !redirect;
        occ_after_pop   = occ_q - OW'(pop);
        rd_ptr_d        = rd_ptr_q + PW'(pop);
        occ_d           = redirect ? '0 : occ_after_pop + OW'(push);

        // Head register preloads the entry that will be at the front after this edge.
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        if (!redirect) begin
            if (occ_after_pop != '0) begin
                head_inst_d = fifo_inst[rd_ptr_d];
                head_pc_d   = fifo_pc[rd_ptr_d];
            end else if (push) begin
                head_inst_d = bus.mem_rdata;
                head_pc_d   = fetch_pc_q;
            end
        end

        if (redirect)
            fetch_pc_d = redirect_target;
        else if (accept)
            fetch_pc_d = fetch_pc_q + 32'd4;
        else
            fetch_pc_d = fetch_pc_q;

        state_d = state_q;
        unique case (state_q)
            IDLE: if (!redirect && occ_d < DEPTH_C) state_d = WAIT;
            WAIT: begin
                if (redirect)
                    state_d = ack_ok ? IDLE : DROP;
                else if (ack_ok)
                    state_d = (occ_d < DEPTH_C) ? WAIT : IDLE;
            end
            DROP: if (ack_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The abandoned request keeps its address until memory acknowledges it.
        mem_addr_d = (state_d == DROP) ? mem_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            valid_q     <= 1'b0;
            head_inst_q <= '0;
            head_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= (state_d != IDLE);
            mem_addr_q  <= mem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            occ_q       <= occ_d;
            valid_q     <= (occ_d != '0);
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PW'(push);
                rd_ptr_q <= rd_ptr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr_q] <= bus.mem_rdata;
            fifo_pc[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    always_comb begin
        out_valid = valid_q;
        out_inst  = head_inst_q;
        out_pc    = head_pc_q;
`ifdef PREFETCH_BYPASS_EN
        if (bypass_hit) begin
            out_valid = 1'b1;
            out_inst  = bus.mem_rdata;
            out_pc    = fetch_pc_q;
        end
`endif
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = out_valid;
    assign bus.inst_out   = out_inst;
    assign bus.pc_out     = out_pc;
    assign bus.npc_out    = out_pc + 32'd4;
    assign bus.occupancy  = occ_q;
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed, table-driven bench for inst_prefetch_buffer (DEPTH=4, RESET_PC=0); one row per clock cycle.
module tb_inst_prefetch_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    inst_prefetch_buffer_if #(.DEPTH(4)) bus ();

    inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic redir, logic [31:0] rpc, logic stall, logic ack,
                                logic [31:0] rdata, logic req, logic [31:0] addr, logic valid,
                                logic [31:0] pc, logic [31:0] inst, logic [2:0] occ);
        vec_t v;
        v.redir = redir;  v.rpc = rpc;     v.stall = stall; v.ack = ack;   v.rdata = rdata;
        v.e_req = req;    v.e_addr = addr; v.e_valid = valid;
        v.e_pc = pc;      v.e_inst = inst; v.e_occ = occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"},   {31'b0, bus.mem_req},    32'd0);
        check({tag, ".addr"},  bus.mem_addr,            32'h0000_0000);
        check({tag, ".valid"}, {31'b0, bus.inst_valid}, 32'd0);
        check({tag, ".inst"},  bus.inst_out,            32'd0);
        check({tag, ".pc"},    bus.pc_out,              32'd0);
        check({tag, ".npc"},   bus.npc_out,             32'd4);
        check({tag, ".occ"},   {29'b0, bus.occupancy},  32'd0);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = 1'b0;
        bus.mem_ack        = 1'b0;
        bus.mem_rdata      = '0;

`ifndef PREFETCH_BYPASS_EN
        //             redir rpc           st ack rdata          req addr          vld pc            inst          occ
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,        0)); // 0 ack ignored
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_0000,  1, 32'h0,         0, 32'h0,         32'h0,        0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_0004,  1, 32'h4,         1, 32'h0,         32'h1000_0000,1));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_0008,  1, 32'h8,         1, 32'h4,         32'h1000_0004,1));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_000C,  1, 32'hC,         1, 32'h8,         32'h1000_0008,1));
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h1000_0010,  1, 32'h10,        1, 32'hC,         32'h1000_000C,1)); // 5 stall fills
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h1000_0014,  1, 32'h14,        1, 32'hC,         32'h1000_000C,2));
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h1000_0018,  1, 32'h18,        1, 32'hC,         32'h1000_000C,3));
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h0,          0, 32'h0,         1, 32'hC,         32'h1000_000C,4)); // full
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h0,          0, 32'h0,         1, 32'hC,         32'h1000_000C,4));
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0,         1, 32'hC,         32'h1000_000C,4)); // 10 release
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h1C,        1, 32'h10,        32'h1000_0010,3));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_001C,  1, 32'h1C,        1, 32'h14,        32'h1000_0014,2));
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h20,        1, 32'h18,        32'h1000_0018,2));
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h20,        1, 32'h1C,        32'h1000_001C,1));
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h20,        0, 32'h1C,        32'h1000_001C,0)); // 15 held
        tbl.push_back(mk(1, 32'h103,       0, 0, 32'h0,          1, 32'h20,        0, 32'h1C,        32'h1000_001C,0)); // 16 -> DROP
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h20,        0, 32'h1C,        32'h1000_001C,0));
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h20,        0, 32'h1C,        32'h1000_001C,0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'hDEAD_BEEF,  1, 32'h20,        0, 32'h1C,        32'h1000_001C,0)); // stale ack
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0,         0, 32'h1C,        32'h1000_001C,0)); // 20
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h2000_0100,  1, 32'h100,       0, 32'h1C,        32'h1000_001C,0));
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h2000_0104,  1, 32'h104,       1, 32'h100,       32'h2000_0100,1));
        tbl.push_back(mk(1, 32'h200,       0, 1, 32'h2000_0108,  1, 32'h108,       1, 32'h100,       32'h2000_0100,2)); // redirect+ack+pop
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0,         0, 32'h100,       32'h2000_0100,0));
        tbl.push_back(mk(1, 32'h300,       0, 0, 32'h0,          1, 32'h200,       0, 32'h100,       32'h2000_0100,0)); // 25 -> DROP
        tbl.push_back(mk(1, 32'hFFFF_FFFE, 0, 0, 32'h0,          1, 32'h200,       0, 32'h100,       32'h2000_0100,0)); // redirect in DROP
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1234_5678,  1, 32'h200,       0, 32'h100,       32'h2000_0100,0));
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0,         0, 32'h100,       32'h2000_0100,0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h3000_FFFC,  1, 32'hFFFF_FFFC, 0, 32'h100,       32'h2000_0100,0));
        tbl.push_back(mk(0, 32'h0,         1, 0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC, 32'h3000_FFFC,1)); // 30 wrap
`else
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_0000,  0, 32'h0,         0, 32'h0,         32'h0,        0));
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_0000,  1, 32'h0,         1, 32'h0,         32'h1000_0000,0)); // bypass
        tbl.push_back(mk(0, 32'h0,         0, 1, 32'h1000_0004,  1, 32'h4,         1, 32'h4,         32'h1000_0004,0));
        tbl.push_back(mk(0, 32'h0,         1, 1, 32'h1000_0008,  1, 32'h8,         1, 32'h8,         32'h1000_0008,0)); // stalled: pushed
        tbl.push_back(mk(0, 32'h0,         0, 0, 32'h0,          1, 32'hC,         1, 32'h8,         32'h1000_0008,1));
`endif

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.redirect_valid = tbl[i].redir;
            bus.redirect_pc    = tbl[i].rpc;
            bus.stall          = tbl[i].stall;
            bus.mem_ack        = tbl[i].ack;
            bus.mem_rdata      = tbl[i].rdata;
            #1;
            check($sformatf("row%0d.req", i),   {31'b0, bus.mem_req},    {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                check($sformatf("row%0d.addr", i), bus.mem_addr, tbl[i].e_addr);
            check($sformatf("row%0d.valid", i), {31'b0, bus.inst_valid}, {31'b0, tbl[i].e_valid});
            check($sformatf("row%0d.pc", i),    bus.pc_out,              tbl[i].e_pc);
            check($sformatf("row%0d.inst", i),  bus.inst_out,            tbl[i].e_inst);
            check($sformatf("row%0d.npc", i),   bus.npc_out,             tbl[i].e_pc + 32'd4);
            check($sformatf("row%0d.occ", i),   {29'b0, bus.occupancy},  {29'b0, tbl[i].e_occ});
            @(negedge clk);
        end

        // Asynchronous reset in the middle of an outstanding request.
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        bus.mem_ack        = 1'b0;
        @(posedge clk);
        #2;
        check("midwait.req", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst.idle_req", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        #1;
        check("post_rst.req",  {31'b0, bus.mem_req}, 32'd1);
        check("post_rst.addr", bus.mem_addr,         32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
